// File: rtl/chacha_pkg.sv
// Shared types, constants and the quarter-round index table for the ChaCha block engine.
package chacha_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned N_WORDS    = 16;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned LOAD_WORDS = 12;
  localparam int unsigned KEY_BASE   = 4;
  localparam int unsigned CTR_IDX    = 12;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ROUND  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  // Word indices feeding one quarter round, in a/b/c/d order.
  typedef struct packed {
    logic [IDX_W-1:0] a;
    logic [IDX_W-1:0] b;
    logic [IDX_W-1:0] c;
    logic [IDX_W-1:0] d;
  } qr_sel_t;

  // "expand 32-byte k", word 0 in the low bits.
  localparam logic [4*WORD_W-1:0] SIGMA = {32'h6b206574, 32'h79622d32,
                                           32'h3320646e, 32'h61707865};

  // Entries 0..3 are the columns, 4..7 the diagonals; entry 0 in the low bits.
  localparam logic [8*16-1:0] QR_TABLE = {16'h349e, 16'h278d, 16'h16bc, 16'h05af,
                                          16'h37bf, 16'h26ae, 16'h159d, 16'h048c};

  function automatic qr_sel_t qr_sel(input logic [2:0] qr);
    return qr_sel_t'(QR_TABLE[32'(qr)*16 +: 16]);
  endfunction

  function automatic word_t sigma(input logic [1:0] i);
    return SIGMA[32'(i)*WORD_W +: WORD_W];
  endfunction

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/chacha_quarter_round.sv
// Combinational ChaCha quarter round on four 32-bit words.
module chacha_quarter_round
  import chacha_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  output logic [31:0] o_a_c,
  output logic [31:0] o_b_c,
  output logic [31:0] o_c_c,
  output logic [31:0] o_d_c
);

  word_t w_a, w_b, w_c, w_d;

  always_comb begin
    w_a = i_a;
    w_b = i_b;
    w_c = i_c;
    w_d = i_d;
    w_a = w_a + w_b;  w_d = rotl(w_d ^ w_a, 16);
    w_c = w_c + w_d;  w_b = rotl(w_b ^ w_c, 12);
    w_a = w_a + w_b;  w_d = rotl(w_d ^ w_a, 8);
    w_c = w_c + w_d;  w_b = rotl(w_b ^ w_c, 7);
  end

  assign o_a_c = w_a;
  assign o_b_c = w_b;
  assign o_c_c = w_c;
  assign o_d_c = w_d;

endmodule

// File: rtl/chacha_round_engine.sv
// Iterative ChaCha block function: 12-word load, one quarter round per cycle,
// 16-word keystream stream-out, and counter+1 regeneration without reload.
module chacha_round_engine
  import chacha_pkg::*;
#(
  parameter int unsigned DOUBLE_ROUNDS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  input  logic        next_block,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [3:0]  out_index,
  output logic        busy
);

  localparam int unsigned STEPS  = 8 * DOUBLE_ROUNDS;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned CNT_W  = 4;

  state_e             r_state, w_state_nxt;
  logic               r_in_ready, r_out_valid, r_busy;
  logic               w_in_ready_nxt, w_out_valid_nxt, w_busy_nxt;
  logic [CNT_W-1:0]   r_load_cnt;
  logic               r_key_loaded;
  logic [STEP_W-1:0]  r_step;
  logic [IDX_W-1:0]   r_out_index;

  word_t r_key [LOAD_WORDS];
  word_t r_work [N_WORDS];
  word_t w_init [N_WORDS];
  word_t w_load_state [N_WORDS];
  word_t w_nb_state [N_WORDS];

  logic    w_load_fire, w_load_last, w_nb_fire, w_round_last, w_out_fire, w_out_last;
  qr_sel_t w_sel;
  word_t   w_qa, w_qb, w_qc, w_qd;
  word_t   w_sum;

  assign w_load_fire  = (r_state == ST_LOAD) && in_valid;
  assign w_load_last  = w_load_fire && (r_load_cnt == CNT_W'(LOAD_WORDS - 1));
  // A pending word always wins over a regenerate request.
  assign w_nb_fire    = (r_state == ST_LOAD) && next_block && !in_valid &&
                        r_key_loaded && (r_load_cnt == '0);
  assign w_round_last = (r_state == ST_ROUND) && (r_step == STEP_W'(STEPS - 1));
  assign w_out_fire   = (r_state == ST_OUTPUT) && out_ready;
  assign w_out_last   = w_out_fire && (r_out_index == IDX_W'(N_WORDS - 1));

  // Initial state: constants plus stored key/counter/nonce.
  always_comb begin
    for (int i = 0; i < 4; i++) w_init[i] = sigma(2'(i));
    for (int k = 0; k < int'(LOAD_WORDS); k++) w_init[KEY_BASE + k] = r_key[k];
  end

  always_comb begin
    for (int i = 0; i < int'(N_WORDS); i++) begin
      w_load_state[i] = w_init[i];
      w_nb_state[i]   = w_init[i];
    end
    w_load_state[N_WORDS-1] = in_word;
    w_nb_state[CTR_IDX]     = w_init[CTR_IDX] + 32'd1;
  end

  assign w_sel = qr_sel(r_step[2:0]);

  chacha_quarter_round u_qr (
    .i_a   (r_work[w_sel.a]),
    .i_b   (r_work[w_sel.b]),
    .i_c   (r_work[w_sel.c]),
    .i_d   (r_work[w_sel.d]),
    .o_a_c (w_qa),
    .o_b_c (w_qb),
    .o_c_c (w_qc),
    .o_d_c (w_qd)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_LOAD:   if (w_load_last || w_nb_fire) w_state_nxt = ST_ROUND;
      ST_ROUND:  if (w_round_last)             w_state_nxt = ST_OUTPUT;
      ST_OUTPUT: if (w_out_last)               w_state_nxt = ST_LOAD;
      default:                                 w_state_nxt = ST_LOAD;
    endcase
    w_in_ready_nxt  = (w_state_nxt == ST_LOAD);
    w_out_valid_nxt = (w_state_nxt == ST_OUTPUT);
    w_busy_nxt      = (w_state_nxt != ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Key store, working state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_cnt   <= '0;
      r_key_loaded <= 1'b0;
      r_step       <= '0;
      r_out_index  <= '0;
    end else begin
      if (w_load_fire) begin
        for (int k = 0; k < int'(LOAD_WORDS); k++)
          if (r_load_cnt == CNT_W'(k)) r_key[k] <= in_word;
        r_load_cnt <= w_load_last ? '0 : r_load_cnt + CNT_W'(1);
      end
      if (w_load_last) begin
        for (int i = 0; i < int'(N_WORDS); i++) r_work[i] <= w_load_state[i];
        r_key_loaded <= 1'b1;
        r_step       <= '0;
      end
      if (w_nb_fire) begin
        r_key[CTR_IDX-KEY_BASE] <= w_nb_state[CTR_IDX];
        for (int i = 0; i < int'(N_WORDS); i++) r_work[i] <= w_nb_state[i];
        r_step <= '0;
      end
      if (r_state == ST_ROUND) begin
        r_work[w_sel.a] <= w_qa;
        r_work[w_sel.b] <= w_qb;
        r_work[w_sel.c] <= w_qc;
        r_work[w_sel.d] <= w_qd;
        r_step          <= r_step + STEP_W'(1);
      end
      if (w_out_fire) r_out_index <= r_out_index + IDX_W'(1);
    end
  end

  assign w_sum     = r_work[r_out_index] + w_init[r_out_index];
  assign out_word  = r_out_valid ? w_sum : '0;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_index = r_out_index;
  assign busy      = r_busy;

endmodule

// File: tb/tb_chacha_round_engine.sv
// Directed bench for chacha_round_engine: quarter-round vector table plus block sequences.
module tb_chacha_round_engine;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        next_block;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [3:0]  out_index;
  logic        busy;
  logic [31:0] qa, qb, qc, qd, qa_o, qb_o, qc_o, qd_o;

  int n_vec = 0;
  int n_bad = 0;

  chacha_round_engine #(.DOUBLE_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .next_block(next_block), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_index(out_index), .busy(busy)
  );

  chacha_quarter_round u_qr (
    .i_a(qa), .i_b(qb), .i_c(qc), .i_d(qd),
    .o_a_c(qa_o), .o_b_c(qb_o), .o_c_c(qc_o), .o_d_c(qd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [31:0]  a, b, c, d;
    logic [127:0] exp;
    string        name;
  } qr_vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] tb_qr(input logic [127:0] v);
    logic [31:0] a, b, c, d;
    a = v[127:96]; b = v[95:64]; c = v[63:32]; d = v[31:0];
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Reference block function; input word k (0..11) maps to state word 4+k.
  function automatic logic [511:0] model_block(input logic [383:0] v);
    logic [31:0]  s [16];
    logic [31:0]  w [16];
    logic [127:0] q;
    int           ix [4];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int k = 0; k < 12; k++) s[4+k] = v[k*32 +: 32];
    for (int i = 0; i < 16; i++) w[i] = s[i];
    for (int dr = 0; dr < 10; dr++)
      for (int half = 0; half < 2; half++)
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) ix[j] = 4*j + ((i + half*j) % 4);
          q = tb_qr({w[ix[0]], w[ix[1]], w[ix[2]], w[ix[3]]});
          w[ix[0]] = q[127:96]; w[ix[1]] = q[95:64]; w[ix[2]] = q[63:32]; w[ix[3]] = q[31:0];
        end
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = w[i] + s[i];
    return r;
  endfunction

  function automatic logic [383:0] pack_in(input logic [255:0] key, input logic [31:0] ctr,
                                           input logic [95:0] nonce);
    return {nonce, ctr, key};
  endfunction

  task automatic load_range(input logic [383:0] v, input int from, input int to);
    for (int k = from; k <= to; k++) begin
      in_valid = 1'b1;
      in_word  = v[k*32 +: 32];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_next();
    next_block = 1'b1;
    tick();
    next_block = 1'b0;
  endtask

  task automatic wait_latency(input string name);
    int cyc = 0;
    chk({name, "_busy"}, {busy, in_ready, out_valid}, 3'b100);
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    chk({name, "_lat"}, 128'(cyc), 128'd80);
  endtask

  task automatic collect(input logic [511:0] exp, input int pct, input string name,
                         output logic [511:0] got);
    int   idx = 0;
    int   guard = 0;
    logic rdy;
    got = '0;
    while (idx < 16 && guard < 2000) begin
      rdy = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      out_ready = rdy;
      chk($sformatf("%s_w%0d", name, idx), {out_valid, out_index, out_word},
          {1'b1, 4'(idx), exp[idx*32 +: 32]});
      if (rdy) got[idx*32 +: 32] = out_word;
      tick();
      if (rdy) idx++;
      guard++;
    end
    out_ready = 1'b0;
    chk({name, "_done"}, {out_valid, busy, in_ready, 5'(idx)}, {3'b001, 5'd16});
  endtask

  localparam logic [255:0] RFC_KEY   =
    256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [95:0]  RFC_NONCE = 96'h00000000_4a000000_09000000;
  localparam logic [255:0] KEY2      =
    256'hdeadbeef_01234567_89abcdef_cafef00d_0badc0de_55aa55aa_f0f0f0f0_12345678;
  localparam logic [95:0]  NONCE2    = 96'h fedcba98_89abcdef_01234567;
  localparam logic [255:0] KEY3      =
    256'h00000001_00000002_00000004_00000008_10000000_20000000_40000000_80000000;
  localparam logic [95:0]  NONCE3    = 96'h a5a5a5a5_5a5a5a5a_00ff00ff;

  initial begin
    qr_vec_t      qv [4];
    logic [383:0] v_rfc, v_wrap, v_alt;
    logic [511:0] got;
    int           n_hi;

    rst = 1'b1; in_valid = 1'b0; in_word = '0; next_block = 1'b0; out_ready = 1'b0;
    qa = '0; qb = '0; qc = '0; qd = '0;
    tick();
    chk("reset", {out_valid, busy, in_ready, out_index, out_word},
        {1'b0, 1'b0, 1'b1, 4'd0, 32'd0});
    tick();
    rst = 1'b0;

    qv[0] = '{32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567,
              {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb}, "qr_rfc211"};
    qv[1] = '{32'h516461b1, 32'h2a5f714c, 32'h53372767, 32'h3d631689,
              {32'hbdb886dc, 32'hcfacafd2, 32'he46bea80, 32'hccc07c79}, "qr_rfc221"};
    qv[2] = '{32'h0, 32'h0, 32'h0, 32'h0, 128'h0, "qr_zero"};
    qv[3] = '{32'h0, 32'h0, 32'h0, 32'h1,
              {32'h10000000, 32'h80800808, 32'h01010010, 32'h01000010}, "qr_d1"};
    for (int i = 0; i < 4; i++) begin
      qa = qv[i].a; qb = qv[i].b; qc = qv[i].c; qd = qv[i].d;
      #1;
      chk(qv[i].name, {qa_o, qb_o, qc_o, qd_o}, qv[i].exp);
    end

    // Regenerate request before any key has been loaded.
    pulse_next();
    repeat (3) tick();
    chk("nb_before_load", {busy, in_ready, out_valid}, 3'b010);

    v_rfc = pack_in(RFC_KEY, 32'd1, RFC_NONCE);
    load_range(v_rfc, 0, 11);
    wait_latency("rfc");
    collect(model_block(v_rfc), 100, "rfc", got);
    chk("rfc_word0", got[31:0], 32'he4e7f110);
    chk("rfc_word1", got[63:32], 32'h15593bd1);

    load_range(v_rfc, 0, 11);
    wait_latency("bp");
    collect(model_block(v_rfc), 30, "bp", got);

    pulse_next();
    wait_latency("nb_ctr2");
    collect(model_block(pack_in(RFC_KEY, 32'd2, RFC_NONCE)), 100, "nb_ctr2", got);

    v_wrap = pack_in(KEY2, 32'hffffffff, NONCE2);
    load_range(v_wrap, 0, 11);
    wait_latency("wrap_ff");
    collect(model_block(v_wrap), 100, "wrap_ff", got);
    pulse_next();
    wait_latency("wrap_0");
    collect(model_block(pack_in(KEY2, 32'd0, NONCE2)), 60, "wrap_0", got);

    // Word and regenerate together: word wins; partial load holds across idle cycles.
    v_alt = pack_in(KEY3, 32'h00000007, NONCE3);
    in_valid = 1'b1; in_word = v_alt[31:0]; next_block = 1'b1;
    tick();
    in_valid = 1'b0; next_block = 1'b0;
    chk("nb_with_valid", {busy, in_ready}, 2'b01);
    pulse_next();
    repeat (3) tick();
    chk("nb_partial", {busy, in_ready, out_valid}, 3'b010);
    load_range(v_alt, 1, 11);
    wait_latency("alt");
    collect(model_block(v_alt), 100, "alt", got);

    load_range(v_rfc, 0, 11);
    repeat (40) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_round", {in_ready, out_valid, busy}, 3'b100);
    pulse_next();
    n_hi = 0;
    repeat (90) begin
      tick();
      if (busy || out_valid) n_hi++;
    end
    chk("nb_after_rst", 128'(n_hi), 128'd0);
    load_range(v_rfc, 0, 11);
    wait_latency("reload");
    collect(model_block(v_rfc), 100, "reload", got);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/chacha_round_engine.md
Name: chacha_round_engine

Overview:
- Iterative ChaCha20 block-function core inside the top-level tile wrapper.
- Downstream of the byte-packing I/O logic: accepts 12 little-endian 32-bit words (key, counter, nonce), inserts the four constant words, runs the double rounds one quarter-round per cycle, then streams 16 keystream words (working state + initial state) to the byte-serialiser.
- Supports regenerating the next block with counter+1 without reloading.

Parameters:
DOUBLE_ROUNDS, 10, double rounds per block (10 = ChaCha20; 4 = ChaCha8, test use only)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  load word offered
in_ready  output  1  engine accepts load word (high only in LOAD)
in_word  input  32  state word; order: words 4..11 key, 12 counter, 13..15 nonce
next_block  input  1  pulse: recompute using stored key/nonce with counter+1
out_valid  output  1  keystream word valid
out_ready  input  1  downstream accepts keystream word
out_word  output  32  keystream word, (work[i] + init[i]) mod 2^32
out_index  output  4  index i of out_word, 0..15
busy  output  1  high in ROUND or OUTPUT

Behaviour:
- One clock `clk`. Reset is synchronous and active-high: `rst` high at a rising edge puts the block in LOAD.
- Reset values:
  - state=LOAD, load count=0, key_loaded=0.
  - in_ready=1, out_valid=0, out_index=0, busy=0, out_word=0.
  - init and work registers may hold any value.
- Constants: init[0..3] = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
- LOAD:
  - in_ready=1. Each in_valid&in_ready cycle writes in_word to init[4+count]; count increments.
  - On the 12th word: copy init to work, set key_loaded=1, clear round and qr counters, go to ROUND.
- next_block in LOAD:
  - Honoured only if key_loaded=1, count=0 and in_valid=0. Otherwise it is ignored.
  - If honoured: init[12] <= init[12]+1 (wraps 0xffffffff->0, no carry into init[13]); work <= the incremented init; go to ROUND.
  - If in_valid and next_block are both high, the word is accepted and next_block is ignored.
- ROUND:
  - One quarter-round per cycle.
  - qr 0..3 are the columns: (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
  - qr 4..7 are the diagonals: (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
  - After 8*DOUBLE_ROUNDS cycles go to OUTPUT with out_index=0.
  - in_ready=0 and busy=1 throughout.
- Quarter round: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7. All additions are mod 2^32.
- OUTPUT:
  - out_valid=1. out_word is combinational from the registered work[out_index] and init[out_index].
  - On out_valid&out_ready, out_index increments.
  - When word 15 is accepted: go to LOAD, out_valid=0, busy=0, count=0.
  - out_word and out_index stay stable while out_ready=0.
- Latency: last load word accepted at edge T -> out_valid high after edge T+8*DOUBLE_ROUNDS (80 cycles for ChaCha20). The same holds from an honoured next_block edge.
- Reset mid-ROUND or mid-OUTPUT:
  - Abort immediately; key_loaded=0; no further out_valid.
  - A fresh 12-word load is required.
- Partial load is never timed out: count holds across idle cycles.

Decomposition:
- Package chacha_pkg holds:
  - the four constant words;
  - the state enum (LOAD, ROUND, OUTPUT);
  - the column/diagonal index table (8 entries × 4 four-bit indices);
  - the word width (32).
- Sub-module chacha_quarter_round: purely combinational, 4×32 in, 4×32 out. The engine muxes the four words selected by the index table into it and writes them back.

Test Plan:
- RFC 8439 §2.1.1 on chacha_quarter_round: a=11111111 b=01020304 c=9b8d6f43 d=01234567 -> a=ea2a92f4 b=cb1cf8ce c=4581472e d=5881c4bb.
- RFC 8439 §2.3.2: key bytes 00..1f, counter=1, nonce 000000090000004a00000000 loaded as LE words, out_ready=1 -> out_valid exactly 80 cycles after the last load edge; word0=0xe4e7f110, word1=0x15593bd1; all 16 words match the golden model.
- Backpressure: same vector with out_ready random 30% high -> identical word sequence, out_index monotonic 0..15, out_word stable while stalled, busy falls after word 15.
- next_block after the §2.3.2 block -> output equals the model with counter=2. Load counter=0xffffffff then next_block -> counter 0; init[13] unchanged; output matches the model.
- next_block before any load, and next_block with in_valid=1 -> ignored: no busy, the word is accepted normally.
- rst asserted at ROUND cycle 40 -> next cycle in_ready=1, out_valid=0, busy=0. A following next_block is ignored; a fresh full load produces the correct block.
